key_event_detector: RTL and testbench
=====================================

// Module: key_event_detector
// PURPOSE
//  NUM_KEYS-channel push-button front end: per-key 2-FF sync, debounce on press AND release,
//  press classification (short / long), optional auto-repeat while held. Emits 1-cycle event
//  pulses plus a debounced level per key. Sits between board pins and LED/menu control logic.
// PARAMETERS
//  NUM_KEYS      4           number of independent key channels
//  ACTIVE_LOW    0           1: pin low = pressed; 0: pin high = pressed
//  DEBOUNCE_CYC  2_000_000   stable cycles required to confirm press or release (>=2)
//  LONG_CYC      50_000_000  hold cycles (from first sync'd press) at which long fires; > DEBOUNCE_CYC
//  REPEAT_EN     1           1: auto-repeat pulses after long press; 0: disabled
//  REPEAT_CYC    10_000_000  period of repeat pulses (>=1)
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous active-low reset
//  key           in   NUM_KEYS  raw asynchronous key pins
//  key_level     out  NUM_KEYS  debounced pressed state (1 = pressed)
//  short_pulse   out  NUM_KEYS  1-cycle pulse: confirmed release of a press shorter than LONG_CYC
//  long_pulse    out  NUM_KEYS  1-cycle pulse: hold reached LONG_CYC (fires while still held)
//  repeat_pulse  out  NUM_KEYS  1-cycle pulse every REPEAT_CYC while held after long_pulse
// BEHAVIOUR
//  - Reset: all outputs 0, sync FFs to released level, every channel IDLE, counters 0.
//  - p = sync'd key XOR ACTIVE_LOW after 2 FFs; all decisions use p only. Channels fully independent.
//  - Per-channel FSM, hold counter cnt (width $clog2(LONG_CYC+1)), repeat counter rcnt, flag was_long:
//    IDLE:    p=1 -> DB_PRESS, cnt<=1.
//    DB_PRESS: p=0 -> IDLE (glitch, no event); else cnt++; cnt==DEBOUNCE_CYC -> HELD, key_level<=1.
//    HELD:    cnt++; cnt==LONG_CYC-1 -> long_pulse, LONG, was_long<=1, rcnt<=0;
//             p=0 -> DB_REL, rel_cnt<=1 (release has priority over long on same cycle).
//    LONG:    REPEAT_EN & rcnt==REPEAT_CYC-1 -> repeat_pulse, rcnt<=0; else rcnt++.
//             p=0 -> DB_REL, rel_cnt<=1.
//    DB_REL:  p=1 -> back to HELD (was_long=0) or LONG (was_long=1), no pulse, cnt/rcnt frozen.
//             rel_cnt==DEBOUNCE_CYC -> IDLE, key_level<=0, short_pulse iff !was_long; was_long<=0.
//  - Latency: key_level rises 2+DEBOUNCE_CYC cycles after clean raw press; short_pulse and
//    key_level fall 2+DEBOUNCE_CYC cycles after clean raw release (same cycle).
//  - long_pulse asserts exactly LONG_CYC cycles after p first rose (excl. 2 sync cycles), once per press.
//  - Exactly one of short/long per confirmed press; repeat only after long; a glitch press yields nothing.
//  - Release bounce inside DB_REL never re-fires long_pulse nor restarts hold timing.
//  - All pulses registered, single cycle, never back-to-back from one source except repeat with REPEAT_CYC=1.
//  - Counters never wrap: cnt stops in LONG, rcnt reloads at REPEAT_CYC-1.
//  - rst_n mid-press: immediate return to reset state; no pulse on reset release even if key held
//    (held key then re-debounces from IDLE as a fresh press).
//  - Elaboration error if LONG_CYC <= DEBOUNCE_CYC or DEBOUNCE_CYC < 2.
// STRUCTURE
//  - Package key_pkg: state enum {IDLE, DB_PRESS, HELD, LONG, DB_REL}, default cycle constants.
//  - Sub-module key_channel_fsm (one key: sync, FSM, counters); top generates NUM_KEYS instances.
// TESTING  (bench params: NUM_KEYS=4, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=6, REPEAT_EN=1)
//  1 key[0] high 3 cycles then low -> no key_level, no pulses (glitch rejected).
//  2 key[0] high 10 cycles, low -> key_level[0]=1 for held span, one short_pulse[0] at level fall.
//  3 key[1] high 40 cycles -> long_pulse[1] at cycle 20 after sync, repeat_pulse[1] at 26,32,38;
//    no short_pulse on release.
//  4 key[2] release bounces (low 2, high 1, low 10) after 12-cycle hold -> exactly one short_pulse,
//    key_level stays 1 through bounce.
//  5 keys 0..3 pressed simultaneously with distinct hold lengths 10/25/10/30 -> per-key events
//    independent, correct type each; ACTIVE_LOW=1 rerun with inverted stimulus gives same events.
//  6 rst_n low at hold cycle 15 of key[3], key held through reset release -> all outputs 0 during
//    reset; afterwards fresh debounce, long_pulse 20 cycles after re-sync, no stale pulse.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared channel state encoding and default timing constants for the key front end
package key_pkg;
    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, LONG, DB_REL} key_state_e;
    localparam int DEF_NUM_KEYS     = 4;
    localparam int DEF_DEBOUNCE_CYC = 2_000_000;
    localparam int DEF_LONG_CYC     = 50_000_000;
    localparam int DEF_REPEAT_CYC   = 10_000_000;
endpackage

// File: rtl/key_channel_fsm.sv
// key_channel_fsm: one key channel - 2-FF sync, press/release debounce, short/long/repeat classification
module key_channel_fsm
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
)(
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam int CW = $clog2(LONG_CYC + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW = $clog2(REPEAT_CYC + 1);
    localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
    localparam logic [DW-1:0] REL_END  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] REP_END  = RW'(REPEAT_CYC - 1);

    key_state_e    state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rel_q, rel_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          was_long_q, was_long_d, level_q, level_d;
    logic          short_q, short_d, long_q, long_d, rep_q, rep_d;
    logic          p;

    assign p = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            rel_q      <= '0;
            rcnt_q     <= '0;
            was_long_q <= 1'b0;
            level_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key ^ ACTIVE_LOW};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rel_q      <= rel_d;
            rcnt_q     <= rcnt_d;
            was_long_q <= was_long_d;
            level_q    <= level_d;
            short_q    <= short_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
        end
    end

    // release always wins over a long/repeat decision on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = p ? DB_PRESS : IDLE;
            DB_PRESS: state_d = !p ? IDLE : (cnt_q == DB_END ? HELD : DB_PRESS);
            HELD:     state_d = !p ? DB_REL : (cnt_q == LONG_END ? LONG : HELD);
            LONG:     state_d = !p ? DB_REL : LONG;
            DB_REL:   state_d = p ? (was_long_q ? LONG : HELD) : (rel_q == REL_END ? IDLE : DB_REL);
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        rcnt_d     = rcnt_q;
        was_long_d = was_long_q;
        level_d    = level_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
        rep_d      = 1'b0;
        case (state_q)
            IDLE: cnt_d = CW'(p);
            DB_PRESS: begin
                cnt_d   = p ? cnt_q + 1'b1 : cnt_q;
                level_d = p && cnt_q == DB_END;
            end
            HELD: begin
                if (!p) rel_d = DW'(1);
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LONG_END) begin
                        long_d     = 1'b1;
                        was_long_d = 1'b1;
                        rcnt_d     = '0;
                    end
                end
            end
            LONG: begin
                if (!p) rel_d = DW'(1);
                else if (rcnt_q == REP_END) begin
                    rcnt_d = '0;
                    rep_d  = REPEAT_EN;
                end else rcnt_d = rcnt_q + 1'b1;
            end
            DB_REL: begin
                if (!p) begin
                    rel_d = rel_q + 1'b1;
                    if (rel_q == REL_END) begin
                        level_d    = 1'b0;
                        short_d    = !was_long_q;
                        was_long_d = 1'b0;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign level        = level_q;
    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = rep_q;
endmodule

// File: rtl/key_event_detector.sv
// key_event_detector: NUM_KEYS independent debounced push-button channels with short/long/repeat events
module key_event_detector
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter bit ACTIVE_LOW   = 1'b0,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] short_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);
    if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC) begin : g_param_check
        $error("key_event_detector: requires DEBOUNCE_CYC >= 2 and LONG_CYC > DEBOUNCE_CYC");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel_fsm #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key         (key[i]),
            .level       (key_level[i]),
            .short_pulse (short_pulse[i]),
            .long_pulse  (long_pulse[i]),
            .repeat_pulse(repeat_pulse[i])
        );
    end
endmodule

// File: tb/tb_key_event_detector.sv
// tb_key_event_detector: directed checks of debounce, short/long/repeat events and reset, active-high and active-low
module tb_key_event_detector;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int LC = 20;
    localparam int RC = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '0;
    logic [NK-1:0] key_n;
    logic [NK-1:0] lvl_a, sh_a, lg_a, rp_a, lvl_b, sh_b, lg_b, rp_b;
    int            n_pass = 0;
    int            n_total = 0;
    int hs0[NK], he0[NK], hs1[NK], he1[NK];
    int rise[NK], fall[NK], sh_at[NK], lg_at[NK], rep0[NK], rep_n[NK];

    assign key_n = ~key;
    always #5 clk = ~clk;

    key_event_detector #(
        .NUM_KEYS(NK), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(DB),
        .LONG_CYC(LC), .REPEAT_EN(1'b1), .REPEAT_CYC(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_level(lvl_a), .short_pulse(sh_a), .long_pulse(lg_a), .repeat_pulse(rp_a)
    );

    key_event_detector #(
        .NUM_KEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DB),
        .LONG_CYC(LC), .REPEAT_EN(1'b1), .REPEAT_CYC(RC)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .key(key_n),
        .key_level(lvl_b), .short_pulse(sh_b), .long_pulse(lg_b), .repeat_pulse(rp_b)
    );

    task automatic chk(input string tag, input int e, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s edge=%0d got=%b expected=%b", tag, e, got, exp);
    endtask

    task automatic clear();
        for (int k = 0; k < NK; k++) begin
            hs0[k] = 0; he0[k] = 0; hs1[k] = 0; he1[k] = 0;
            rise[k] = -1; fall[k] = -1; sh_at[k] = -1; lg_at[k] = -1; rep0[k] = -1; rep_n[k] = 0;
        end
    endtask

    // key k raw-high on edges [a0,b0) and [a1,b1); expected event edges are hand-computed
    task automatic set_key(input int k, input int a0, input int b0, input int a1, input int b1,
                           input int r, input int f, input int s, input int l, input int r0, input int rn);
        hs0[k] = a0; he0[k] = b0; hs1[k] = a1; he1[k] = b1;
        rise[k] = r; fall[k] = f; sh_at[k] = s; lg_at[k] = l; rep0[k] = r0; rep_n[k] = rn;
    endtask

    task automatic check_all(input int e);
        logic [NK-1:0] el, es, eg, er;
        for (int k = 0; k < NK; k++) begin
            el[k] = rise[k] >= 0 && e >= rise[k] && e < fall[k];
            es[k] = e == sh_at[k];
            eg[k] = e == lg_at[k];
            er[k] = rep_n[k] > 0 && e >= rep0[k] && (e - rep0[k]) % RC == 0 && (e - rep0[k]) / RC < rep_n[k];
        end
        chk("level_hi", e, lvl_a, el);
        chk("short_hi", e, sh_a, es);
        chk("long_hi", e, lg_a, eg);
        chk("repeat_hi", e, rp_a, er);
        chk("level_lo", e, lvl_b, el);
        chk("short_lo", e, sh_b, es);
        chk("long_lo", e, lg_b, eg);
        chk("repeat_lo", e, rp_b, er);
    endtask

    task automatic check_zero(input int e);
        chk("rst_level", e, lvl_a | lvl_b, '0);
        chk("rst_pulses", e, sh_a | lg_a | rp_a | sh_b | lg_b | rp_b, '0);
    endtask

    task automatic run(input int n);
        for (int e = 0; e < n; e++) begin
            for (int k = 0; k < NK; k++)
                key[k] = (e >= hs0[k] && e < he0[k]) || (e >= hs1[k] && e < he1[k]);
            @(posedge clk); #1;
            check_all(e);
        end
    endtask

    initial begin
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            check_zero(e);
        end
        rst_n = 1'b1;
        // 1: 3-cycle glitch rejected
        clear(); set_key(0, 0, 3, 0, 0, -1, -1, -1, -1, -1, 0); run(12);
        // 2: 10-cycle press -> short
        clear(); set_key(0, 0, 10, 0, 0, 5, 15, 15, -1, -1, 0); run(20);
        // 3: 40-cycle hold -> long at 21, repeats 27/33/39, no short
        clear(); set_key(1, 0, 40, 0, 0, 5, 45, -1, 21, 27, 3); run(50);
        // 4: release bounce low2/high1/low -> single short, level held through bounce
        clear(); set_key(2, 0, 12, 14, 15, 5, 20, 20, -1, -1, 0); run(25);
        // 5: simultaneous holds 10/25/10/30
        clear();
        set_key(0, 0, 10, 0, 0, 5, 15, 15, -1, -1, 0);
        set_key(1, 0, 25, 0, 0, 5, 30, -1, 21, -1, 0);
        set_key(2, 0, 10, 0, 0, 5, 15, 15, -1, -1, 0);
        set_key(3, 0, 30, 0, 0, 5, 35, -1, 21, 27, 1);
        run(40);
        // 6: reset at hold cycle 15 of key[3], key held through reset release
        clear(); set_key(3, 0, 1000, 0, 0, 5, 1000, -1, -1, -1, 0); run(16);
        rst_n = 1'b0;
        #1 check_zero(100);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            check_zero(101 + e);
        end
        rst_n = 1'b1;
        clear(); set_key(3, 0, 40, 0, 0, 5, 45, -1, 21, 27, 3); run(46);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
